// File: rtl/btb_update_unit.sv
// btb_update_unit: checks each resolved control transfer against the
// prediction carried down the pipe, raises flush/redirect on a mismatch,
// and queues BTB write/invalidate requests for the BTB write port.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   i_res_*               resolved instruction from EX/MEM
//   i_pred_hit/_target    prediction made at fetch
//   o_flush/o_redirect_pc squash request and correct next PC (combinational)
//   o_upd_* / i_upd_ready queue head toward the BTB write port (valid/ready)
//   o_q_full              queue holds QDEPTH entries (registered state only)
//   o_*_cnt               saturating statistics counters
module btb_update_unit #(
    parameter int ADDR_W = 16,
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_res_valid,
    input  logic              i_res_stall,
    input  logic              i_res_is_branch,
    input  logic [ADDR_W-1:0] i_res_pc,
    input  logic              i_res_taken,
    input  logic [ADDR_W-1:0] i_res_target,
    input  logic              i_pred_hit,
    input  logic [ADDR_W-1:0] i_pred_target,
    output logic              o_flush,
    output logic [ADDR_W-1:0] o_redirect_pc,
    output logic              o_upd_valid,
    input  logic              i_upd_ready,
    output logic [ADDR_W-1:0] o_upd_pc,
    output logic [ADDR_W-1:0] o_upd_target,
    output logic              o_q_full,
    output logic [CNT_W-1:0]  o_resolve_cnt,
    output logic [CNT_W-1:0]  o_mispredict_cnt,
    output logic [CNT_W-1:0]  o_drop_cnt
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PTR_W:0] QD = (PTR_W+1)'(QDEPTH);
    localparam logic [PTR_W:0] ONE_CNT = (PTR_W+1)'(1);

    logic [ADDR_W-1:0] r_q_pc  [QDEPTH];
    logic [ADDR_W-1:0] r_q_tgt [QDEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W:0]    r_count;
    logic [CNT_W-1:0]  r_resolve_cnt;
    logic [CNT_W-1:0]  r_mispredict_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_acc;
    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_actual;
    logic              w_mis;
    logic              w_upd_taken;
    logic              w_upd_inval;
    logic              w_need;
    logic [ADDR_W-1:0] w_new_tgt;
    logic [PTR_W-1:0]  w_tail_last;
    logic              w_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_tail_popping;
    logic              w_coal;
    logic              w_push;
    logic              w_drop;

    assign w_acc    = reset_n & i_res_valid & ~i_res_stall;
    assign w_seq_pc = i_res_pc + ADDR_W'(1);
    assign w_actual = i_res_taken ? i_res_target : w_seq_pc;
    assign w_mis    = w_acc & (w_actual != i_pred_target);

    assign o_flush       = w_mis;
    assign o_redirect_pc = w_acc ? w_actual : '0;

    // A taken target of 0 naturally becomes an invalidate entry.
    assign w_upd_taken = i_res_taken &
                         (~i_pred_hit | (i_pred_target != i_res_target));
    assign w_upd_inval = ~i_res_taken & i_res_is_branch & i_pred_hit;
    assign w_need      = w_acc & (w_upd_taken | w_upd_inval);
    assign w_new_tgt   = i_res_taken ? i_res_target : '0;

    assign w_tail_last = r_tail - PTR_W'(1);
    assign w_valid     = (r_count != '0);
    assign w_full      = (r_count == QD);
    assign w_pop       = w_valid & i_upd_ready;

    // The youngest entry is leaving only when it is also the head.
    assign w_tail_popping = w_pop & (r_count == ONE_CNT);
    assign w_coal = w_need & w_valid & ~w_tail_popping &
                    (r_q_pc[w_tail_last] == i_res_pc);
    assign w_push = w_need & ~w_coal & (~w_full | w_pop);
    assign w_drop = w_need & ~w_coal & w_full & ~w_pop;

    assign o_upd_valid  = w_valid;
    assign o_upd_pc     = w_valid ? r_q_pc[r_head] : '0;
    assign o_upd_target = w_valid ? r_q_tgt[r_head] : '0;
    assign o_q_full     = w_full;

    assign o_resolve_cnt    = r_resolve_cnt;
    assign o_mispredict_cnt = r_mispredict_cnt;
    assign o_drop_cnt       = r_drop_cnt;

    // Entry storage needs no reset; contents are masked by count.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (w_push) begin
                r_q_pc[r_tail]  <= i_res_pc;
                r_q_tgt[r_tail] <= w_new_tgt;
            end
            if (w_coal) begin
                r_q_tgt[w_tail_last] <= w_new_tgt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + ONE_CNT;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - ONE_CNT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_resolve_cnt    <= '0;
            r_mispredict_cnt <= '0;
            r_drop_cnt       <= '0;
        end else begin
            if (w_acc && (r_resolve_cnt != '1)) begin
                r_resolve_cnt <= r_resolve_cnt + CNT_W'(1);
            end
            if (w_mis && (r_mispredict_cnt != '1)) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_btb_update_unit.sv
// Directed testbench for btb_update_unit.
// Each task drives one scenario and checks outputs inline.
module tb_btb_update_unit;

    logic        clk;
    logic        reset_n;
    logic        i_res_valid;
    logic        i_res_stall;
    logic        i_res_is_branch;
    logic [15:0] i_res_pc;
    logic        i_res_taken;
    logic [15:0] i_res_target;
    logic        i_pred_hit;
    logic [15:0] i_pred_target;
    logic        o_flush;
    logic [15:0] o_redirect_pc;
    logic        o_upd_valid;
    logic        i_upd_ready;
    logic [15:0] o_upd_pc;
    logic [15:0] o_upd_target;
    logic        o_q_full;
    logic [15:0] o_resolve_cnt;
    logic [15:0] o_mispredict_cnt;
    logic [15:0] o_drop_cnt;

    int checks;
    int failures;

    btb_update_unit #(.ADDR_W(16), .QDEPTH(4), .CNT_W(16)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_res_valid      (i_res_valid),
        .i_res_stall      (i_res_stall),
        .i_res_is_branch  (i_res_is_branch),
        .i_res_pc         (i_res_pc),
        .i_res_taken      (i_res_taken),
        .i_res_target     (i_res_target),
        .i_pred_hit       (i_pred_hit),
        .i_pred_target    (i_pred_target),
        .o_flush          (o_flush),
        .o_redirect_pc    (o_redirect_pc),
        .o_upd_valid      (o_upd_valid),
        .i_upd_ready      (i_upd_ready),
        .o_upd_pc         (o_upd_pc),
        .o_upd_target     (o_upd_target),
        .o_q_full         (o_q_full),
        .o_resolve_cnt    (o_resolve_cnt),
        .o_mispredict_cnt (o_mispredict_cnt),
        .o_drop_cnt       (o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic br, input logic [15:0] pc,
                           input logic tk, input logic [15:0] tgt,
                           input logic hit, input logic [15:0] ptgt);
        i_res_valid     = 1'b1;
        i_res_is_branch = br;
        i_res_pc        = pc;
        i_res_taken     = tk;
        i_res_target    = tgt;
        i_pred_hit      = hit;
        i_pred_target   = ptgt;
        #1;
    endtask

    task automatic clr_res();
        i_res_valid     = 1'b0;
        i_res_stall     = 1'b0;
        i_res_is_branch = 1'b0;
        i_res_pc        = '0;
        i_res_taken     = 1'b0;
        i_res_target    = '0;
        i_pred_hit      = 1'b0;
        i_pred_target   = '0;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        i_upd_ready = 1'b0;
        clr_res();
        step();
        step();
        set_res(1'b0, 16'h0050, 1'b1, 16'h0077, 1'b0, 16'h0051);
        checks++;
        if (o_flush !== 1'b0 || o_redirect_pc !== 16'h0) begin
            failures++;
            $display("FAIL reset_flush flush=%b redir=%h want 0 0000",
                     o_flush, o_redirect_pc);
        end
        checks++;
        if (o_upd_valid !== 1'b0 || o_q_full !== 1'b0 ||
            o_upd_pc !== 16'h0 || o_upd_target !== 16'h0) begin
            failures++;
            $display("FAIL reset_queue v=%b full=%b pc=%h tgt=%h want 0",
                     o_upd_valid, o_q_full, o_upd_pc, o_upd_target);
        end
        checks++;
        if (o_resolve_cnt !== 16'd0 || o_mispredict_cnt !== 16'd0 ||
            o_drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt res=%0d mis=%0d drop=%0d want 0",
                     o_resolve_cnt, o_mispredict_cnt, o_drop_cnt);
        end
        clr_res();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_hit_correct();
        set_res(1'b0, 16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040);
        checks++;
        if (o_flush !== 1'b0 || o_redirect_pc !== 16'h0040) begin
            failures++;
            $display("FAIL hit_comb flush=%b redir=%h want 0 0040",
                     o_flush, o_redirect_pc);
        end
        step();
        clr_res();
        checks++;
        if (o_upd_valid !== 1'b0 || o_resolve_cnt !== 16'd1 ||
            o_mispredict_cnt !== 16'd0) begin
            failures++;
            $display("FAIL hit_state v=%b res=%0d mis=%0d want 0 1 0",
                     o_upd_valid, o_resolve_cnt, o_mispredict_cnt);
        end
    endtask

    task automatic test_miss_taken();
        set_res(1'b0, 16'h0020, 1'b1, 16'h0005, 1'b0, 16'h0021);
        checks++;
        if (o_flush !== 1'b1 || o_redirect_pc !== 16'h0005) begin
            failures++;
            $display("FAIL miss_comb flush=%b redir=%h want 1 0005",
                     o_flush, o_redirect_pc);
        end
        step();
        clr_res();
        checks++;
        if (o_upd_valid !== 1'b1 || o_upd_pc !== 16'h0020 ||
            o_upd_target !== 16'h0005 || o_mispredict_cnt !== 16'd1) begin
            failures++;
            $display("FAIL miss_entry v=%b pc=%h tgt=%h mis=%0d want 1 0020 0005 1",
                     o_upd_valid, o_upd_pc, o_upd_target, o_mispredict_cnt);
        end
        i_upd_ready = 1'b1;
        step();
        i_upd_ready = 1'b0;
        checks++;
        if (o_upd_valid !== 1'b0) begin
            failures++;
            $display("FAIL miss_drain v=%b want 0", o_upd_valid);
        end
    endtask

    task automatic test_not_taken();
        set_res(1'b1, 16'h0012, 1'b0, 16'h0030, 1'b1, 16'h0030);
        checks++;
        if (o_flush !== 1'b1 || o_redirect_pc !== 16'h0013) begin
            failures++;
            $display("FAIL nt_comb flush=%b redir=%h want 1 0013",
                     o_flush, o_redirect_pc);
        end
        step();
        clr_res();
        checks++;
        if (o_upd_valid !== 1'b1 || o_upd_pc !== 16'h0012 ||
            o_upd_target !== 16'h0000) begin
            failures++;
            $display("FAIL nt_inval v=%b pc=%h tgt=%h want 1 0012 0000",
                     o_upd_valid, o_upd_pc, o_upd_target);
        end
        i_upd_ready = 1'b1;
        step();
        i_upd_ready = 1'b0;
        set_res(1'b1, 16'hFFFF, 1'b0, 16'h1234, 1'b0, 16'h0000);
        checks++;
        if (o_flush !== 1'b0 || o_redirect_pc !== 16'h0000) begin
            failures++;
            $display("FAIL nt_wrap flush=%b redir=%h want 0 0000",
                     o_flush, o_redirect_pc);
        end
        step();
        clr_res();
        checks++;
        if (o_upd_valid !== 1'b0 || o_resolve_cnt !== 16'd4 ||
            o_mispredict_cnt !== 16'd2) begin
            failures++;
            $display("FAIL nt_cnt v=%b res=%0d mis=%0d want 0 4 2",
                     o_upd_valid, o_resolve_cnt, o_mispredict_cnt);
        end
    endtask

    task automatic test_full_drop();
        logic [15:0] pc;
        for (int i = 0; i < 5; i++) begin
            pc = 16'h0100 + 16'(i);
            set_res(1'b0, pc, 1'b1, 16'h0200 + 16'(i), 1'b0, pc + 16'h1);
            step();
            if (i == 3) begin
                checks++;
                if (o_q_full !== 1'b1 || o_drop_cnt !== 16'd0) begin
                    failures++;
                    $display("FAIL full_four full=%b drop=%0d want 1 0",
                             o_q_full, o_drop_cnt);
                end
            end
        end
        clr_res();
        checks++;
        if (o_q_full !== 1'b1 || o_drop_cnt !== 16'd1 ||
            o_resolve_cnt !== 16'd9 || o_mispredict_cnt !== 16'd7) begin
            failures++;
            $display("FAIL full_drop full=%b drop=%0d res=%0d mis=%0d want 1 1 9 7",
                     o_q_full, o_drop_cnt, o_resolve_cnt, o_mispredict_cnt);
        end
        i_upd_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (o_upd_valid !== 1'b1 || o_upd_pc !== 16'h0100 + 16'(i) ||
                o_upd_target !== 16'h0200 + 16'(i)) begin
                failures++;
                $display("FAIL drain_order[%0d] v=%b pc=%h tgt=%h want 1 %h %h",
                         i, o_upd_valid, o_upd_pc, o_upd_target,
                         16'h0100 + 16'(i), 16'h0200 + 16'(i));
            end
            step();
        end
        i_upd_ready = 1'b0;
        checks++;
        if (o_upd_valid !== 1'b0 || o_q_full !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty v=%b full=%b want 0 0",
                     o_upd_valid, o_q_full);
        end
    endtask

    task automatic test_coalesce();
        set_res(1'b0, 16'h0044, 1'b1, 16'h0100, 1'b0, 16'h0045);
        step();
        set_res(1'b0, 16'h0044, 1'b1, 16'h0200, 1'b0, 16'h0045);
        step();
        clr_res();
        checks++;
        if (o_upd_valid !== 1'b1 || o_upd_pc !== 16'h0044 ||
            o_upd_target !== 16'h0200) begin
            failures++;
            $display("FAIL coal_entry v=%b pc=%h tgt=%h want 1 0044 0200",
                     o_upd_valid, o_upd_pc, o_upd_target);
        end
        i_upd_ready = 1'b1;
        step();
        i_upd_ready = 1'b0;
        checks++;
        if (o_upd_valid !== 1'b0) begin
            failures++;
            $display("FAIL coal_count v=%b want 0 after one pop", o_upd_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pc;
        for (int i = 0; i < 4; i++) begin
            pc = 16'h0300 + 16'(i);
            set_res(1'b0, pc, 1'b1, 16'h0400 + 16'(i), 1'b0, pc + 16'h1);
            step();
        end
        set_res(1'b0, 16'h0310, 1'b1, 16'h0410, 1'b0, 16'h0311);
        i_upd_ready = 1'b1;
        #1;
        checks++;
        if (o_upd_pc !== 16'h0300 || o_q_full !== 1'b1) begin
            failures++;
            $display("FAIL b2b_pre pc=%h full=%b want 0300 1",
                     o_upd_pc, o_q_full);
        end
        step();
        clr_res();
        i_upd_ready = 1'b0;
        checks++;
        if (o_q_full !== 1'b1 || o_drop_cnt !== 16'd1 ||
            o_upd_pc !== 16'h0301 || o_resolve_cnt !== 16'd16) begin
            failures++;
            $display("FAIL b2b_post full=%b drop=%0d pc=%h res=%0d want 1 1 0301 16",
                     o_q_full, o_drop_cnt, o_upd_pc, o_resolve_cnt);
        end
        i_upd_ready = 1'b1;
        step();
        step();
        step();
        checks++;
        if (o_upd_pc !== 16'h0310 || o_upd_target !== 16'h0410 ||
            o_upd_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_wrap v=%b pc=%h tgt=%h want 1 0310 0410",
                     o_upd_valid, o_upd_pc, o_upd_target);
        end
        step();
        i_upd_ready = 1'b0;
    endtask

    task automatic test_stall();
        set_res(1'b0, 16'h0500, 1'b1, 16'h0600, 1'b0, 16'h0501);
        i_res_stall = 1'b1;
        #1;
        checks++;
        if (o_flush !== 1'b0 || o_redirect_pc !== 16'h0000) begin
            failures++;
            $display("FAIL stall_comb flush=%b redir=%h want 0 0000",
                     o_flush, o_redirect_pc);
        end
        step();
        clr_res();
        checks++;
        if (o_upd_valid !== 1'b0 || o_resolve_cnt !== 16'd16 ||
            o_mispredict_cnt !== 16'd14 || o_drop_cnt !== 16'd1) begin
            failures++;
            $display("FAIL stall_state v=%b res=%0d mis=%0d drop=%0d want 0 16 14 1",
                     o_upd_valid, o_resolve_cnt, o_mispredict_cnt, o_drop_cnt);
        end
    endtask

    task automatic test_reset_mid_drain();
        set_res(1'b0, 16'h0700, 1'b1, 16'h0800, 1'b0, 16'h0701);
        step();
        set_res(1'b0, 16'h0701, 1'b1, 16'h0801, 1'b0, 16'h0702);
        step();
        clr_res();
        checks++;
        if (o_resolve_cnt !== 16'd18 || o_upd_pc !== 16'h0700) begin
            failures++;
            $display("FAIL pre_reset res=%0d pc=%h want 18 0700",
                     o_resolve_cnt, o_upd_pc);
        end
        i_upd_ready = 1'b1;
        reset_n = 1'b0;
        step();
        checks++;
        if (o_upd_valid !== 1'b0 || o_upd_pc !== 16'h0 ||
            o_resolve_cnt !== 16'd0 || o_mispredict_cnt !== 16'd0 ||
            o_drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset v=%b pc=%h res=%0d mis=%0d drop=%0d want 0",
                     o_upd_valid, o_upd_pc, o_resolve_cnt,
                     o_mispredict_cnt, o_drop_cnt);
        end
        reset_n = 1'b1;
        i_upd_ready = 1'b0;
        step();
        checks++;
        if (o_upd_valid !== 1'b0 || o_q_full !== 1'b0) begin
            failures++;
            $display("FAIL post_reset v=%b full=%b want 0 0",
                     o_upd_valid, o_q_full);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_hit_correct();
        test_miss_taken();
        test_not_taken();
        test_full_drop();
        test_coalesce();
        test_back_to_back();
        test_stall();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btb_update_unit.md
# btb_update_unit

Resolution-side companion to the fetch-stage branch target buffer. It sits at the EX/MEM boundary and compares each resolved control-transfer instruction against the prediction carried down the pipeline. On a mismatch it raises flush and the redirect PC. It also queues BTB write/invalidate requests and drains them to the BTB write port over a valid/ready handshake, keeping performance counters alongside.

## Interface
- ADDR_W, 16, PC/target width
- QDEPTH, 4, update queue depth (power of two, ≥2)
- CNT_W, 16, statistics counter width
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  reset, synchronous, active-low
- res_valid  in  1  EX/MEM holds a control-transfer instruction (JMP, JAL, BEQ/BNE/BGZ/BLZ, JPR, JRL)
- res_stall  in  1  EX/MEM frozen this cycle; resolution ignored
- res_is_branch  in  1  instruction is a conditional branch
- res_pc  in  ADDR_W  PC of resolving instruction
- res_taken  in  1  actual outcome (1 for all unconditional jumps)
- res_target  in  ADDR_W  actual target when taken
- pred_hit  in  1  BTB hit at fetch
- pred_target  in  ADDR_W  next PC used at fetch (res_pc+1 on miss)
- flush  out  1  squash IF/ID/EX, load redirect_pc
- redirect_pc  out  ADDR_W  correct next PC
- upd_valid  out  1  queue head valid
- upd_ready  in  1  BTB write port accepts head
- upd_pc  out  ADDR_W  BTB index to write
- upd_target  out  ADDR_W  target to store; 0 = invalidate entry
- q_full  out  1  queue holds QDEPTH entries
- resolve_cnt, mispredict_cnt, drop_cnt  out  CNT_W each  statistics

## Operation
- Accepted resolution: acc = reset_n & res_valid & !res_stall.
- actual_next = res_taken ? res_target : res_pc+1, computed modulo 2^ADDR_W (0xFFFF+1 = 0x0000).
- Mispredict: mis = acc & (actual_next != pred_target).
- flush = mis, combinational, same cycle. redirect_pc = actual_next, driven whenever acc; 0 otherwise.
- Update request needed (need_upd) when acc and either:
  - res_taken & (!pred_hit | pred_target != res_target) → entry (res_pc, res_target).
  - !res_taken & res_is_branch & pred_hit → entry (res_pc, 0), an invalidate.
  - A taken target of 0x0000 is written as 0, i.e. it becomes an invalidate. This is intended; address 0 is never cached.
- Queue is a circular FIFO of QDEPTH {pc,target} entries, with head ptr, tail ptr, and a count of width log2(QDEPTH)+1.
  - pop = upd_valid & upd_ready.
  - Coalesce: if need_upd, count>0, the tail entry's pc == res_pc, and the tail entry is not being popped this cycle, overwrite that entry's target. count is unchanged.
  - Otherwise push if count<QDEPTH or pop. If full with no pop, drop the request and increment drop_cnt.
  - Push and pop in the same cycle: count unchanged, both pointers advance and wrap at QDEPTH.
- upd_valid = (count!=0). upd_pc/upd_target reflect the head entry. They are held stable while upd_valid & !upd_ready.
- Counters saturate at all-ones:
  - resolve_cnt increments on acc.
  - mispredict_cnt increments on mis.
  - drop_cnt increments on each dropped request.
- res_stall=1 suppresses flush, queue pushes and counter increments. Pops continue.

## Timing
- flush/redirect_pc: 0-cycle latency, combinational from the res_* and pred_* inputs.
- Queue entry is visible on upd_valid the cycle after the accepting edge. Minimum resolve→BTB write latency is 1 cycle.
- A coalesced target is visible the cycle after the edge.
- Reset (synchronous, reset_n=0 at an edge): count/pointers 0, upd_valid 0, all counters 0, stored entries don't-care.
- While reset_n=0: flush 0 and redirect_pc 0. upd_pc/upd_target = 0 after the first reset edge.
- Reset mid-drain: queued entries are discarded. upd_valid is 0 from the cycle after the reset edge, even if upd_ready is high.
- q_full is registered-state derived (count==QDEPTH). It carries no combinational path from res_*.

## Test plan
- Predict hit correct: res_pc=0x0010, taken, target 0x0040, pred_hit=1, pred_target=0x0040 → flush=0, no push, resolve_cnt=1.
- BTB miss taken: res_pc=0x0020, target 0x0005, pred_hit=0, pred_target=0x0021 → flush=1, redirect 0x0005; next cycle upd_valid=1, upd_pc=0x0020, upd_target=0x0005.
- Hit but not taken BEQ: pred_target=0x0030, res_pc=0x0012 → flush=1, redirect 0x0013; queued (0x0012, 0x0000). Wrap case: res_pc=0xFFFF not taken → redirect 0x0000.
- upd_ready=0, five distinct-pc updates with QDEPTH=4 → q_full=1 after four, fifth dropped, drop_cnt=1. Then upd_ready=1 → four entries emitted in FIFO order.
- Two back-to-back updates with the same pc 0x0044 (targets 0x0100 then 0x0200) with upd_ready=0 → a single entry holding 0x0200, count=1. Then push+pop on a full queue in one cycle → count stays 4 with no drop.
- res_stall=1 with a mispredicting resolution → flush=0, counters unchanged. reset_n=0 mid-drain → upd_valid=0 and all counters 0 the next cycle.
